// File: rtl/mio_arbiter.sv
// Two-port round-robin arbiter onto the shared MIO memory bus.
// Registers the winning request, waits for mem_ready (bounded by TIMEOUT) and pulses a per-port ack.
module mio_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt_id,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Counter value seen in the last permitted ACCESS cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic              prio_q;
    logic              we_q;
    logic [7:0]        cnt_q;
    logic              ack0_q, ack1_q, err_q, busy_q, gnt_q, rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    logic any_req, win_d, win_we_d;

    assign any_req  = req0 | req1;
    // Contention goes to the preferred port; otherwise the lone requester wins.
    assign win_d    = (req0 & req1) ? prio_q : req1;
    assign win_we_d = win_d ? we1 : we0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= 8'd0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q   <= win_d;
                        we_q    <= win_we_d;
                        addr_q  <= win_d ? addr1 : addr0;
                        wdata_q <= win_d ? wdata1 : wdata0;
                        rd_q    <= !win_we_d;
                        wr_q    <= win_we_d;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_ready || cnt_q == CNT_LAST) begin
                        // mem_ready beats a coincident timeout.
                        if (mem_ready) begin
                            if (!we_q) rdata_q <= mem_rdata;
                            err_q <= 1'b0;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        ack0_q  <= !gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    prio_q  <= !gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter (TIMEOUT=4): reset, read, waited write,
// contention, timeout and ready-at-last-cycle, all against hand-computed values.
module tb_mio_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err, busy, gnt_id, mem_rd, mem_wr;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;

    mio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
        .busy(busy), .gnt_id(gnt_id), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0; mem_ready = 0;
        step(); step();
        check("rst_busy",  32'(busy),   32'd0);
        check("rst_ack",   32'({ack1, ack0}), 32'd0);
        check("rst_rdata", rdata,        32'd0);
        reset_n = 1'b1;
        step();

        // Reset asserted mid-ACCESS
        req0 = 1; addr0 = 32'h80;
        step();
        check("pre_rst_rd", 32'(mem_rd), 32'd1);
        step();
        #2 reset_n = 1'b0;
        #1;
        check("async_rd",     32'(mem_rd), 32'd0);
        check("async_busy",   32'(busy),   32'd0);
        check("async_addr",   mem_addr,     32'd0);
        check("async_flags",  32'({ack0, ack1, err, gnt_id, mem_wr}), 32'd0);
        check("async_rdata",  rdata,        32'd0);
        req0 = 0; req1 = 1; addr1 = 32'h44;
        mem_ready = 1; mem_rdata = 32'h11112222;
        reset_n = 1'b1;
        step();
        check("post_rst_gnt",  32'(gnt_id), 32'd1);
        check("post_rst_addr", mem_addr,     32'h44);
        step();
        check("post_rst_ack1", 32'(ack1),   32'd1);
        check("post_rst_ack0", 32'(ack0),   32'd0);
        req1 = 0;
        step();
        check("post_rst_idle", 32'({busy, ack1}), 32'd0);

        // Contention: both held high, zero wait
        req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
        mem_rdata = 32'hA5A5A5A5;
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("cont_ack0_c%0d", c), 32'(ack0), 32'((c == 2) || (c == 8)));
            check($sformatf("cont_ack1_c%0d", c), 32'(ack1), 32'((c == 5) || (c == 11)));
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                check($sformatf("cont_gnt_c%0d", c), 32'(gnt_id), 32'((c == 4) || (c == 10)));
                check($sformatf("cont_addr_c%0d", c), mem_addr, (c == 4 || c == 10) ? 32'h20 : 32'h10);
            end
            if (c == 11) begin
                req0 = 0; req1 = 0;
            end
        end

        // Single read, memory ready in first ACCESS cycle
        req0 = 1; we0 = 0; addr0 = 32'h100;
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        step();
        check("rd_strobe", 32'(mem_rd), 32'd1);
        check("rd_addr",   mem_addr,     32'h100);
        check("rd_busy",   32'(busy),   32'd1);
        step();
        check("rd_ack0",  32'(ack0), 32'd1);
        check("rd_ack1",  32'(ack1), 32'd0);
        check("rd_data",  rdata,      32'hDEADBEEF);
        check("rd_err",   32'(err),  32'd0);
        check("rd_strobe_off", 32'(mem_rd), 32'd0);
        req0 = 0;
        step();
        check("rd_ack_once", 32'(ack0), 32'd0);

        // Write from port 1 with three wait states
        req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'h12345678;
        mem_ready = 0; mem_rdata = 32'hBAD0BAD0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("wr_strobe_c%0d", c), 32'(mem_wr), 32'd1);
            check($sformatf("wr_data_c%0d", c),   mem_wdata,    32'h12345678);
            check($sformatf("wr_noack_c%0d", c),  32'(ack1),   32'd0);
            if (c == 4) mem_ready = 1;
        end
        step();
        check("wr_ack1",  32'(ack1),   32'd1);
        check("wr_err",   32'(err),    32'd0);
        check("wr_rdata", rdata,        32'hDEADBEEF);
        check("wr_off",   32'(mem_wr), 32'd0);
        req1 = 0; we1 = 0; mem_ready = 0;
        step();
        check("wr_ack_once", 32'(ack1), 32'd0);

        // Timeout on a port 0 read, then simultaneous requests go to port 1
        req0 = 1; addr0 = 32'h200; mem_rdata = 32'h55555555;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("to_strobe_c%0d", c), 32'(mem_rd), 32'd1);
            check($sformatf("to_noack_c%0d", c),  32'(ack0),   32'd0);
        end
        step();
        check("to_ack0",  32'(ack0), 32'd1);
        check("to_err",   32'(err),  32'd1);
        check("to_rdata", rdata,      32'd0);
        req1 = 1; we1 = 0; addr1 = 32'h60; mem_ready = 1; mem_rdata = 32'h77;
        step();
        check("to_idle_err", 32'(err), 32'd0);
        step();
        check("to_next_gnt",  32'(gnt_id), 32'd1);
        check("to_next_addr", mem_addr,     32'h60);
        req0 = 0;
        step();
        check("to_next_ack1", 32'(ack1), 32'd1);
        check("to_next_data", rdata,      32'h77);
        req1 = 0; mem_ready = 0;
        step();

        // mem_ready only in the last permitted ACCESS cycle
        req0 = 1; addr0 = 32'h300; mem_rdata = 32'hCAFEF00D;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("bd_strobe_c%0d", c), 32'(mem_rd), 32'd1);
            if (c == 4) mem_ready = 1;
        end
        step();
        check("bd_ack0",  32'(ack0), 32'd1);
        check("bd_err",   32'(err),  32'd0);
        check("bd_rdata", rdata,      32'hCAFEF00D);
        req0 = 0; mem_ready = 0;
        step();
        check("bd_idle", 32'({busy, ack0}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
